// File: rtl/thread_slot_sched.sv
// Round-robin assignment of READY thread contexts to core computation slots.
// Tracks per-thread IDLE/READY/RUNNING state and flags protocol misuse.
module thread_slot_sched #(
    parameter int unsigned N_THREADS     = 16,
    parameter int unsigned N_CORES       = 4,
    parameter int unsigned IDLE_CNT_W    = 16,
    localparam int unsigned N_THREADS_MSB = $clog2(N_THREADS) - 1,
    localparam int unsigned N_CORES_MSB   = (N_CORES > 1) ? $clog2(N_CORES) - 1 : 0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [N_CORES-1:0]      core_start,
    input  logic                    ctx_num,
    input  logic                    rdy_set,
    input  logic [N_THREADS_MSB:0]  rdy_num,
    input  logic                    done,
    input  logic [N_THREADS_MSB:0]  done_num,
    output logic                    issue_valid,
    output logic [N_THREADS_MSB:0]  issue_thread,
    output logic [N_CORES_MSB:0]    issue_core,
    output logic                    issue_ctx,
    output logic [IDLE_CNT_W-1:0]   idle_slots,
    output logic                    err
);

    localparam int unsigned THR_W  = N_THREADS_MSB + 1;
    localparam int unsigned CORE_W = N_CORES_MSB + 1;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_READY   = 2'd1,
        T_RUNNING = 2'd2
    } thr_state_t;

    logic [N_THREADS-1:0][1:0] thr_st, thr_st_nxt;
    logic [THR_W-1:0]          rr_ptr, rr_ptr_nxt;

    logic                      slot;
    logic                      multi_start;
    logic [CORE_W-1:0]         core_idx;
    logic                      found;
    logic [THR_W-1:0]          found_idx;
    logic [THR_W-1:0]          probe;
    logic                      proto_err;

    logic                      issue_valid_nxt;
    logic [THR_W-1:0]          issue_thread_nxt;
    logic [CORE_W-1:0]         issue_core_nxt;
    logic                      issue_ctx_nxt;
    logic [IDLE_CNT_W-1:0]     idle_slots_nxt;
    logic                      err_nxt;

    // Slot decode: lowest set core_start bit wins, extra bits are a protocol error.
    always_comb begin
        slot        = |core_start;
        multi_start = |(core_start & (core_start - N_CORES'(1)));
        core_idx    = '0;
        for (int c = N_CORES - 1; c >= 0; c--) begin
            if (core_start[c]) core_idx = CORE_W'(c);
        end
    end

    // Round-robin search over registered state, starting just after rr_ptr.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        probe     = '0;
        for (int i = 1; i <= N_THREADS; i++) begin
            probe = THR_W'(rr_ptr + THR_W'(i));
            if (!found && thr_st[probe] == T_READY) begin
                found     = 1'b1;
                found_idx = probe;
            end
        end
    end

    // Thread state update; done is applied before rdy_set so done+rdy_set on a RUNNING thread lands in READY.
    always_comb begin
        thr_st_nxt = thr_st;
        proto_err  = 1'b0;
        for (int t = 0; t < N_THREADS; t++) begin
            if (done && done_num == THR_W'(t)) begin
                if (thr_st[t] == T_RUNNING) thr_st_nxt[t] = T_IDLE;
                else                        proto_err     = 1'b1;
            end
            if (rdy_set && rdy_num == THR_W'(t)) begin
                if (thr_st_nxt[t] == T_RUNNING) proto_err     = 1'b1;
                else                            thr_st_nxt[t] = T_READY;
            end
            if (slot && found && found_idx == THR_W'(t)) thr_st_nxt[t] = T_RUNNING;
        end
    end

    always_comb begin
        issue_valid_nxt  = 1'b0;
        issue_thread_nxt = issue_thread;
        issue_core_nxt   = issue_core;
        issue_ctx_nxt    = issue_ctx;
        idle_slots_nxt   = idle_slots;
        rr_ptr_nxt       = rr_ptr;
        err_nxt          = err | proto_err | multi_start;
        if (slot) begin
            if (found) begin
                issue_valid_nxt  = 1'b1;
                issue_thread_nxt = found_idx;
                issue_core_nxt   = core_idx;
                issue_ctx_nxt    = ctx_num;
                rr_ptr_nxt       = found_idx;
            end else if (idle_slots != '1) begin
                idle_slots_nxt = idle_slots + IDLE_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            thr_st       <= '0;
            rr_ptr       <= THR_W'(N_THREADS - 1);
            issue_valid  <= 1'b0;
            issue_thread <= '0;
            issue_core   <= '0;
            issue_ctx    <= 1'b0;
            idle_slots   <= '0;
            err          <= 1'b0;
        end else begin
            thr_st       <= thr_st_nxt;
            rr_ptr       <= rr_ptr_nxt;
            issue_valid  <= issue_valid_nxt;
            issue_thread <= issue_thread_nxt;
            issue_core   <= issue_core_nxt;
            issue_ctx    <= issue_ctx_nxt;
            idle_slots   <= idle_slots_nxt;
            err          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_thread_slot_sched.sv
// Directed bench for thread_slot_sched: inputs driven and outputs sampled on the falling edge.
module tb_thread_slot_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  core_start;
    logic        ctx_num;
    logic        rdy_set;
    logic [3:0]  rdy_num;
    logic        done;
    logic [3:0]  done_num;
    logic        issue_valid;
    logic [3:0]  issue_thread;
    logic [1:0]  issue_core;
    logic        issue_ctx;
    logic [15:0] idle_slots;
    logic        err;

    int errors = 0;
    int checks = 0;

    thread_slot_sched dut (
        .CLK          (CLK),
        .RST          (RST),
        .core_start   (core_start),
        .ctx_num      (ctx_num),
        .rdy_set      (rdy_set),
        .rdy_num      (rdy_num),
        .done         (done),
        .done_num     (done_num),
        .issue_valid  (issue_valid),
        .issue_thread (issue_thread),
        .issue_core   (issue_core),
        .issue_ctx    (issue_ctx),
        .idle_slots   (idle_slots),
        .err          (err)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        core_start = '0; ctx_num = 1'b0;
        rdy_set = 1'b0; rdy_num = '0;
        done = 1'b0; done_num = '0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic set_rdy(input logic [3:0] n);
        @(negedge CLK);
        rdy_set = 1'b1; rdy_num = n;
        @(negedge CLK);
        rdy_set = 1'b0;
    endtask

    task automatic do_done(input logic [3:0] n);
        @(negedge CLK);
        done = 1'b1; done_num = n;
        @(negedge CLK);
        done = 1'b0;
    endtask

    // One-cycle slot pulse; returns at the falling edge where the registered issue is visible.
    task automatic slot(input logic [3:0] cs, input logic ctx);
        @(negedge CLK);
        core_start = cs; ctx_num = ctx;
        @(negedge CLK);
        core_start = '0; ctx_num = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        #12;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", issue_valid); end
        checks++; if (issue_thread !== 4'd0) begin errors++; $display("FAIL rst_thread got=%0d exp=0", issue_thread); end
        checks++; if (issue_core !== 2'd0) begin errors++; $display("FAIL rst_core got=%0d exp=0", issue_core); end
        checks++; if (issue_ctx !== 1'b0) begin errors++; $display("FAIL rst_ctx got=%b exp=0", issue_ctx); end
        checks++; if (idle_slots !== 16'd0) begin errors++; $display("FAIL rst_idle got=%0d exp=0", idle_slots); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        @(negedge CLK);
        RST = 1'b0;
        slot(4'b0001, 1'b0);
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got=%b exp=0", issue_valid); end
        checks++; if (idle_slots !== 16'd1) begin errors++; $display("FAIL empty_idle got=%0d exp=1", idle_slots); end
    endtask

    task automatic test_round_robin();
        do_reset();
        set_rdy(4'd3); set_rdy(4'd7); set_rdy(4'd12);
        slot(4'b0001, 1'b0);
        checks++; if ({issue_valid, issue_thread, issue_core, issue_ctx} !== {1'b1, 4'd3, 2'd0, 1'b0}) begin
            errors++; $display("FAIL rr_issue0 got=v%b t%0d c%0d x%b exp=v1 t3 c0 x0", issue_valid, issue_thread, issue_core, issue_ctx); end
        @(negedge CLK);
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rr_pulse_width got=%b exp=0", issue_valid); end
        slot(4'b0010, 1'b1);
        checks++; if ({issue_valid, issue_thread, issue_core, issue_ctx} !== {1'b1, 4'd7, 2'd1, 1'b1}) begin
            errors++; $display("FAIL rr_issue1 got=v%b t%0d c%0d x%b exp=v1 t7 c1 x1", issue_valid, issue_thread, issue_core, issue_ctx); end
        slot(4'b0100, 1'b0);
        checks++; if ({issue_valid, issue_thread, issue_core, issue_ctx} !== {1'b1, 4'd12, 2'd2, 1'b0}) begin
            errors++; $display("FAIL rr_issue2 got=v%b t%0d c%0d x%b exp=v1 t12 c2 x0", issue_valid, issue_thread, issue_core, issue_ctx); end
        slot(4'b1000, 1'b1);
        checks++; if ({issue_valid, issue_thread, issue_core, issue_ctx} !== {1'b0, 4'd12, 2'd2, 1'b0}) begin
            errors++; $display("FAIL rr_unfilled_hold got=v%b t%0d c%0d x%b exp=v0 t12 c2 x0", issue_valid, issue_thread, issue_core, issue_ctx); end
        checks++; if (idle_slots !== 16'd1) begin errors++; $display("FAIL rr_idle got=%0d exp=1", idle_slots); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rr_err got=%b exp=0", err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_rdy(4'd0); set_rdy(4'd1);
        @(negedge CLK);
        core_start = 4'b0001; ctx_num = 1'b1;
        @(negedge CLK);
        core_start = 4'b0010; ctx_num = 1'b0;
        checks++; if ({issue_valid, issue_thread, issue_core, issue_ctx} !== {1'b1, 4'd0, 2'd0, 1'b1}) begin
            errors++; $display("FAIL b2b_first got=v%b t%0d c%0d x%b exp=v1 t0 c0 x1", issue_valid, issue_thread, issue_core, issue_ctx); end
        @(negedge CLK);
        core_start = '0;
        checks++; if ({issue_valid, issue_thread, issue_core, issue_ctx} !== {1'b1, 4'd1, 2'd1, 1'b0}) begin
            errors++; $display("FAIL b2b_second got=v%b t%0d c%0d x%b exp=v1 t1 c1 x0", issue_valid, issue_thread, issue_core, issue_ctx); end
    endtask

    task automatic test_wrap();
        do_reset();
        set_rdy(4'd14);
        slot(4'b0001, 1'b0);
        checks++; if ({issue_valid, issue_thread} !== {1'b1, 4'd14}) begin
            errors++; $display("FAIL wrap_setup got=v%b t%0d exp=v1 t14", issue_valid, issue_thread); end
        set_rdy(4'd1); set_rdy(4'd15);
        slot(4'b0010, 1'b0);
        checks++; if ({issue_valid, issue_thread} !== {1'b1, 4'd15}) begin
            errors++; $display("FAIL wrap_first got=v%b t%0d exp=v1 t15", issue_valid, issue_thread); end
        slot(4'b0100, 1'b1);
        checks++; if ({issue_valid, issue_thread} !== {1'b1, 4'd1}) begin
            errors++; $display("FAIL wrap_second got=v%b t%0d exp=v1 t1", issue_valid, issue_thread); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_rdy(4'd7);
        slot(4'b0001, 1'b0);
        @(negedge CLK);
        done = 1'b1; done_num = 4'd7; rdy_set = 1'b1; rdy_num = 4'd7;
        @(negedge CLK);
        idle_inputs();
        slot(4'b0010, 1'b1);
        checks++; if ({issue_valid, issue_thread, issue_core} !== {1'b1, 4'd7, 2'd1}) begin
            errors++; $display("FAIL done_rdy_reissue got=v%b t%0d c%0d exp=v1 t7 c1", issue_valid, issue_thread, issue_core); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL done_rdy_err got=%b exp=0", err); end
        // rdy_set coinciding with a slot is not visible to that slot's search
        do_reset();
        @(negedge CLK);
        core_start = 4'b0001; rdy_set = 1'b1; rdy_num = 4'd5;
        @(negedge CLK);
        idle_inputs();
        checks++; if ({issue_valid, idle_slots} !== {1'b0, 16'd1}) begin
            errors++; $display("FAIL rdy_during_slot got=v%b idle%0d exp=v0 idle1", issue_valid, idle_slots); end
        slot(4'b0001, 1'b0);
        checks++; if ({issue_valid, issue_thread} !== {1'b1, 4'd5}) begin
            errors++; $display("FAIL rdy_during_slot_next got=v%b t%0d exp=v1 t5", issue_valid, issue_thread); end
        // done coinciding with a slot: thread was RUNNING at search time
        @(negedge CLK);
        core_start = 4'b0001; done = 1'b1; done_num = 4'd5;
        @(negedge CLK);
        idle_inputs();
        checks++; if ({issue_valid, idle_slots, err} !== {1'b0, 16'd2, 1'b0}) begin
            errors++; $display("FAIL done_during_slot got=v%b idle%0d e%b exp=v0 idle2 e0", issue_valid, idle_slots, err); end
    endtask

    task automatic test_errors();
        do_reset();
        do_done(4'd4);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_done_idle got=%b exp=1", err); end
        slot(4'b0001, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
        do_reset();
        set_rdy(4'd9);
        do_done(4'd9);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_done_ready got=%b exp=1", err); end
        slot(4'b0001, 1'b0);
        checks++; if ({issue_valid, issue_thread} !== {1'b1, 4'd9}) begin
            errors++; $display("FAIL err_done_ready_state got=v%b t%0d exp=v1 t9", issue_valid, issue_thread); end
        do_reset();
        set_rdy(4'd9);
        slot(4'b0110, 1'b1);
        checks++; if ({issue_valid, issue_thread, issue_core, issue_ctx} !== {1'b1, 4'd9, 2'd1, 1'b1}) begin
            errors++; $display("FAIL multi_start_issue got=v%b t%0d c%0d x%b exp=v1 t9 c1 x1", issue_valid, issue_thread, issue_core, issue_ctx); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL multi_start_err got=%b exp=1", err); end
        do_reset();
        set_rdy(4'd3);
        slot(4'b0001, 1'b0);
        set_rdy(4'd3);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_rdy_running got=%b exp=1", err); end
        slot(4'b0001, 1'b0);
        checks++; if ({issue_valid, idle_slots} !== {1'b0, 16'd1}) begin
            errors++; $display("FAIL err_rdy_running_state got=v%b idle%0d exp=v0 idle1", issue_valid, idle_slots); end
    endtask

    task automatic test_reset_mid_and_saturate();
        int issued;
        do_reset();
        for (int t = 1; t <= 5; t++) set_rdy(4'(t));
        issued = 0;
        for (int s = 0; s < 5; s++) begin
            slot(4'b0001, 1'b0);
            if (issue_valid === 1'b1 && issue_thread === 4'(s + 1)) issued++;
        end
        checks++; if (issued != 5) begin errors++; $display("FAIL mid_setup got=%0d exp=5", issued); end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        slot(4'b0001, 1'b0);
        checks++; if ({issue_valid, idle_slots, err} !== {1'b0, 16'd1, 1'b0}) begin
            errors++; $display("FAIL mid_reset got=v%b idle%0d e%b exp=v0 idle1 e0", issue_valid, idle_slots, err); end
        @(negedge CLK);
        core_start = 4'b0001;
        repeat (65536) @(negedge CLK);
        core_start = '0;
        @(negedge CLK);
        checks++; if ({issue_valid, idle_slots} !== {1'b0, 16'hFFFF}) begin
            errors++; $display("FAIL saturate got=v%b idle%h exp=v0 idleffff", issue_valid, idle_slots); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_wrap();
        test_same_cycle();
        test_errors();
        test_reset_mid_and_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/thread_slot_sched.md
Name: thread_slot_sched

Overview:
- Assigns ready threads to computation slots produced by core_ctrl.
- Each core_start pulse (one core, one context) opens a slot. The scheduler picks the next READY thread round-robin, marks it RUNNING and issues it to the core's input loader.
- Threads return to IDLE on completion.
- Sits between core_ctrl, the per-thread load logic and the SHA512 cores.

Parameters:
N_THREADS, 16, number of thread contexts (power of 2)
N_THREADS_MSB, `MSB(N_THREADS-1), thread number MSB
N_CORES, 4, number of cores
N_CORES_MSB, `MSB(N_CORES-1), core number MSB
IDLE_CNT_W, 16, width of idle-slot counter

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
core_start  in  N_CORES  one-hot slot pulse from core_ctrl
ctx_num  in  1  context of current slot, sampled with core_start
rdy_set  in  1  pulse: thread rdy_num became ready
rdy_num  in  N_THREADS_MSB+1  thread made ready
done  in  1  pulse: thread done_num finished computation
done_num  in  N_THREADS_MSB+1  finished thread
issue_valid  out  1  one-cycle pulse: slot assigned
issue_thread  out  N_THREADS_MSB+1  assigned thread
issue_core  out  N_CORES_MSB+1  core owning the slot
issue_ctx  out  1  context of the slot
idle_slots  out  IDLE_CNT_W  saturating count of unfilled slots
err  out  1  sticky protocol error

Behaviour:
- Per-thread state, 2 bits: IDLE(0), READY(1), RUNNING(2). 3 is unreachable and is treated as IDLE.
- Reset (async, RST=1) drives:
  - all threads to IDLE
  - rr_ptr=N_THREADS-1
  - issue_valid=0, issue_thread=0, issue_core=0, issue_ctx=0
  - idle_slots=0, err=0
- Reset mid-operation drops all READY/RUNNING state immediately. There is no pending issue after release.
- Slot handling:
  - On a cycle with |core_start, search for a READY thread starting at rr_ptr+1 with wrap-around modulo N_THREADS. Take the first READY thread found.
  - Found: next cycle issue_valid=1 and issue_thread=found. issue_core is the encoded core_start index; issue_ctx is ctx_num as sampled. The thread becomes RUNNING and rr_ptr is set to found.
  - Not found: issue_valid stays 0, idle_slots increments (saturates at all-ones) and rr_ptr is unchanged.
- Latency: exactly 1 cycle from core_start to issue_valid. Outputs are registered.
- issue_thread, issue_core and issue_ctx hold their last values while issue_valid=0.
- More than one core_start bit set in one cycle: err sets, the lowest set index is serviced and the others are dropped.
- rdy_set:
  - IDLE→READY.
  - Set on a READY thread is a no-op.
  - Set on a RUNNING thread sets err; state is unchanged.
- done:
  - RUNNING→IDLE.
  - done on an IDLE or READY thread sets err; state is unchanged.
- Same-cycle events, all resolved in a single update:
  - done and rdy_set on the same thread that is RUNNING: result is READY.
  - rdy_set on thread T while a slot search runs the same cycle: T is not eligible that cycle (the search uses registered state), but it becomes READY.
  - done on thread T the same cycle as a slot: T is not eligible, since it was RUNNING at search time.
  - Distinct-thread events apply independently.
- err clears only on RST.
- Slots arrive at most once per COMP_INTERVAL (22) cycles, but the block must tolerate back-to-back core_start pulses on consecutive cycles.

Test Plan:
- Reset → all outputs 0 and err=0. core_start=4'b0001 with no READY threads → issue_valid stays 0 and idle_slots=1.
- rdy_set threads 3, 7, 12, then core_start pulses 0001, 0010, 0100, 1000 (ctx 0,1,0,1) → issues 3/core0/ctx0, 7/core1/ctx1, 12/core2/ctx0. The fourth slot is unfilled and idle_slots=1.
- Wrap-around: threads 15 and 1 READY, rr_ptr=14 → first slot issues 15, second issues 1.
- done(7) and rdy_set(7) in the same cycle while 7 is RUNNING → 7 READY. The next slot issues 7 when it is first after rr_ptr; err stays 0.
- Protocol errors:
  - done on an IDLE thread → err=1.
  - core_start=4'b0110 → only core 1 is serviced and err=1.
- Assert RST while 5 threads are RUNNING, then release and pulse core_start → no issue and idle_slots=1. Run 65536 empty slots → idle_slots saturates at 16'hFFFF.
